// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared widths, op codes and state encodings for the iterative divider
package div_unit_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic DIV_OP_UNSIGNED = 1'b0;
    localparam logic DIV_OP_SIGNED   = 1'b1;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_RUN  = 2'd1,
        DIV_ST_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);

    logic [W:0] rem_sh;
    logic [W:0] diff;

    // Partial remainder stays below the divisor, so the shifted value fits in W+1 bits.
    assign rem_sh = {rem, quo[W-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    always_comb begin
        if (!diff[W]) begin
            rem_next = diff[W-1:0];
            quo_next = {quo[W-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[W-1:0];
            quo_next = {quo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed/unsigned 32-bit divider for the EX stage
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic              op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero,
    output logic              of
);

    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              fast_zero_q, fast_zero_d;
    logic              fast_of_q, fast_of_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic              div_zero_q, div_zero_d;
    logic              of_q, of_d;

    logic              is_signed;
    logic              dvd_neg;
    logic              dvs_neg;
    logic [DATA_W-1:0] dvd_abs;
    logic [DATA_W-1:0] dvs_abs;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quo;

    assign is_signed = (op != DIV_OP_UNSIGNED);
    assign dvd_neg   = is_signed & dividend[DATA_W-1];
    assign dvs_neg   = is_signed & divisor[DATA_W-1];
    assign dvd_abs   = dvd_neg ? -dividend : dividend;
    assign dvs_abs   = dvs_neg ? -divisor : divisor;

    div_step #(.W(DATA_W)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        fast_zero_d = fast_zero_q;
        fast_of_d   = fast_of_q;
        busy_d      = busy_q;
        done_d      = DISABLE;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        of_d        = of_q;

        if (flush) begin
            state_d = DIV_ST_IDLE;
            busy_d  = DISABLE;
        end else begin
            case (state_q)
                DIV_ST_IDLE: begin
                    if (start) begin
                        busy_d      = ENABLE;
                        div_zero_d  = DISABLE;
                        of_d        = DISABLE;
                        cnt_d       = '0;
                        rem_d       = '0;
                        dvsr_d      = dvs_abs;
                        neg_q_d     = dvd_neg ^ dvs_neg;
                        neg_r_d     = dvd_neg;
                        fast_zero_d = (divisor == '0);
                        fast_of_d   = is_signed && (dividend == MIN_NEG) && (divisor == '1);
                        // Divide-by-zero reports the raw dividend, so keep it unsigned-magnitude free.
                        quo_d       = (divisor == '0) ? dividend : dvd_abs;
                        state_d     = ((divisor == '0) || fast_of_d) ? DIV_ST_FIN : DIV_ST_RUN;
                    end
                end
                DIV_ST_RUN: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DIV_ST_FIN;
                    end
                end
                DIV_ST_FIN: begin
                    state_d = DIV_ST_IDLE;
                    busy_d  = DISABLE;
                    done_d  = ENABLE;
                    if (fast_zero_q) begin
                        quotient_d  = '1;
                        remainder_d = quo_q;
                        div_zero_d  = ENABLE;
                    end else if (fast_of_q) begin
                        quotient_d  = MIN_NEG;
                        remainder_d = '0;
                        of_d        = ENABLE;
                    end else begin
                        quotient_d  = neg_q_q ? -quo_q : quo_q;
                        remainder_d = neg_r_q ? -rem_q : rem_q;
                    end
                end
                default: begin
                    state_d = DIV_ST_IDLE;
                    busy_d  = DISABLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DIV_ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            fast_zero_q <= 1'b0;
            fast_of_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            fast_zero_q <= fast_zero_d;
            fast_of_q   <= fast_of_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            of_q        <= of_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign of        = of_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and randomized self-checking bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic        op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic        of;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .of        (of)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge; the accepting edge is the next one.
    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input logic eof, input int elat);
        int n;
        int bc;
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk({tag, ".busy_acc"}, 32'(busy), 32'd1);
        chk({tag, ".done_acc"}, 32'(done), 32'd0);
        n  = 0;
        bc = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(elat));
        chk({tag, ".busy_cyc"}, 32'(bc), 32'(elat));
        chk({tag, ".quo"}, quotient, eq);
        chk({tag, ".rem"}, remainder, er);
        chk({tag, ".dz"}, 32'(div_zero), 32'(edz));
        chk({tag, ".of"}, 32'(of), 32'(eof));
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk({tag, ".no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0]        a, b, eq, er;
        logic signed [31:0] sa, sb;
        logic               o;
        int                 n;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.quo", quotient, 32'd0);
        chk("rst.rem", remainder, 32'd0);
        chk("rst.dz", 32'(div_zero), 32'd0);
        chk("rst.of", 32'(of), 32'd0);

        run_op("u100_7",   1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33);
        run_op("sn100_7",  1'b1, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0, 33);
        run_op("s100_n7",  1'b1, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0, 33);
        run_op("sn100_n7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 1'b0, 33);
        run_op("u_dz",     1'b0, 32'h1234,     32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 1);
        run_op("s_dz",     1'b1, 32'hFFFFFF9C, 32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1'b1, 1'b0, 1);
        run_op("s_of",     1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1, 1);
        run_op("u_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0, 33);
        run_op("s_min_2",  1'b1, 32'h80000000, 32'd2,          32'hC0000000,   32'd0,          1'b0, 1'b0, 33);
        run_op("u_max_1",  1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 33);
        // Issued in the done cycle of the previous op: back-to-back accept.
        run_op("b2b",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0, 33);

        // start while busy is ignored
        @(posedge clk); #1;
        op = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 dividend = 32'd7; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 10;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign.latency", 32'(n), 32'd33);
        chk("ign.quo", quotient, 32'd100);
        chk("ign.rem", remainder, 32'd0);

        // flush during RUN
        @(posedge clk); #1;
        dividend = 32'd500; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.busy", 32'(busy), 32'd0);
        chk("flush.done", 32'(done), 32'd0);
        chk("flush.quo", quotient, 32'd100);
        chk("flush.rem", remainder, 32'd0);
        no_done("flush", 40);

        // flush and start together: start is dropped
        dividend = 32'd9; divisor = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("fs.busy", 32'(busy), 32'd0);
        no_done("fs", 40);
        chk("fs.quo", quotient, 32'd100);

        // reset in the middle of RUN
        dividend = 32'd9; divisor = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.done", 32'(done), 32'd0);
        chk("mrst.quo", quotient, 32'd0);
        chk("mrst.rem", remainder, 32'd0);
        chk("mrst.dz", 32'(div_zero), 32'd0);
        chk("mrst.of", 32'(of), 32'd0);
        no_done("mrst", 40);

        // randomized pairs against the language's own division operators
        for (int i = 0; i < 150; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(4, 31);
            if (i % 5 == 0) b = -b;
            if (b == 32'd0) b = 32'd1;
            if (o && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            if (o) begin
                sa = a; sb = b;
                eq = 32'(sa / sb);
                er = 32'(sa % sb);
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op($sformatf("rnd%0d", i), o, a, b, eq, er, 1'b0, 1'b0, 33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
